match_pair_buffer: RTL and testbench

- Sits directly downstream of the descriptor matcher.
- Consumes its one-cycle match pulses (valid_match plus a packed pair of seed coordinates).
- Rejects back-to-back duplicates, computes per-match displacement, and buffers results in a FIFO.
- Drains the FIFO over a valid/ready stream toward the transform-estimation stage and reports per-frame statistics when the matcher's frame is complete.

---
 rtl/match_pair_buffer_pkg.sv | 21 ++
 rtl/match_pair_buffer_sync_fifo.sv | 80 ++++++++
 rtl/match_pair_buffer.sv | 150 +++++++++++++++
 tb/tb_match_pair_buffer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/match_pair_buffer_pkg.sv
// Shared definitions for the match pair buffer.
// Holds coordinate widths, seed field offsets, the FIFO entry width and the packed
// FIFO entry type {seed1, dx, dy}.
package match_pair_buffer_pkg;

    localparam int unsigned DW     = 8;       // bits per coordinate component
    localparam int unsigned CNT_DW = 2 * DW;  // packed seed {y, x}

    localparam int unsigned X_LSB = 0;
    localparam int unsigned Y_LSB = DW;

    // seed1 plus two signed (DW+1)-bit displacements
    localparam int unsigned ENTRY_W = CNT_DW + 2 * DW + 2;

    typedef struct packed {
        logic [CNT_DW-1:0] seed1;
        logic [DW:0]       dx;
        logic [DW:0]       dy;
    } entry_t;

endpackage

// File: rtl/match_pair_buffer_sync_fifo.sv
// Synchronous FIFO with a registered show-ahead output.
// The output register always mirrors the head entry, which stays in storage until it
// is consumed, so the total capacity is exactly DEPTH words.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   wr_en, wr_data  write request and data
//   wr_ok           a write this cycle would be accepted (not full, or a read frees a slot)
//   rd_valid        head word valid
//   rd_ready        consumer accepts the head word
//   rd_data         head word
module match_pair_buffer_sync_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ok,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = out_valid_q && rd_ready;
    assign wr_ok   = !full || do_pop;
    assign do_push = wr_en && wr_ok;

    assign wr_ptr_d = wr_ptr_q + (AW + 1)'(do_push);
    assign rd_ptr_d = rd_ptr_q + (AW + 1)'(do_pop);

    always_comb begin
        out_valid_d = (wr_ptr_d != rd_ptr_d);
        out_data_d  = out_data_q;
        if (out_valid_d) begin
            // The next head may be the word being written right now.
            if (rd_ptr_d == wr_ptr_q) begin
                out_data_d = wr_data;
            end else begin
                out_data_d = mem_q[rd_ptr_d[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign rd_valid = out_valid_q;
    assign rd_data  = out_data_q;

endmodule

// File: rtl/match_pair_buffer.sv
// Match pair buffer: sits behind the descriptor matcher, drops back-to-back duplicate
// matches, computes per-match displacement, buffers {seed1, dx, dy} in a FIFO drained
// over a valid/ready stream, and reports per-frame statistics on match_done.
// Coordinate widths (DW, CNT_DW) come from match_pair_buffer_pkg.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   valid_match            one-cycle match strobe
//   match_addr             {seed2, seed1}, seed1 (image 1) in the low half
//   match_done             one-cycle end-of-frame pulse
//   m_valid/m_ready        output stream handshake
//   m_seed1, m_dx, m_dy    output word: image-1 seed and signed displacement
//   overflow               sticky: a match was dropped on a full FIFO
//   stat_valid             one-cycle statistics strobe
//   stat_cnt, stat_sum_dx, stat_sum_dy  per-frame totals, held until the next strobe
module match_pair_buffer
    import match_pair_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6,
    parameter int unsigned SUM_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_match,
    input  logic [2*CNT_DW-1:0] match_addr,
    input  logic                match_done,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [CNT_DW-1:0]   m_seed1,
    output logic [DW:0]         m_dx,
    output logic [DW:0]         m_dy,
    output logic                overflow,
    output logic                stat_valid,
    output logic [AW:0]         stat_cnt,
    output logic [SUM_W-1:0]    stat_sum_dx,
    output logic [SUM_W-1:0]    stat_sum_dy
);

    logic [CNT_DW-1:0] seed1, seed2;
    logic [DW:0]       dx, dy;
    logic [SUM_W-1:0]  dx_ext, dy_ext;

    logic [2*CNT_DW-1:0] last_q;
    logic                last_valid_q;
    logic                is_dup, want_wr, wr_ok, accepted, drop_full;

    logic [AW:0]      cnt_q, cnt_inc;
    logic [SUM_W-1:0] sum_dx_q, sum_dx_inc;
    logic [SUM_W-1:0] sum_dy_q, sum_dy_inc;

    logic             overflow_q;
    logic             stat_valid_q;
    logic [AW:0]      stat_cnt_q;
    logic [SUM_W-1:0] stat_sum_dx_q, stat_sum_dy_q;

    entry_t wr_entry, rd_entry;

    assign seed1 = match_addr[CNT_DW-1:0];
    assign seed2 = match_addr[2*CNT_DW-1:CNT_DW];

    // Zero-extend both coordinates so the difference is a proper signed DW+1 value.
    assign dx = {1'b0, seed2[X_LSB +: DW]} - {1'b0, seed1[X_LSB +: DW]};
    assign dy = {1'b0, seed2[Y_LSB +: DW]} - {1'b0, seed1[Y_LSB +: DW]};

    assign dx_ext = {{(SUM_W - DW - 1){dx[DW]}}, dx};
    assign dy_ext = {{(SUM_W - DW - 1){dy[DW]}}, dy};

    assign is_dup    = last_valid_q && (match_addr == last_q);
    assign want_wr   = valid_match && !is_dup;
    assign accepted  = want_wr && wr_ok;
    assign drop_full = want_wr && !wr_ok;

    assign wr_entry = '{seed1: seed1, dx: dx, dy: dy};

    match_pair_buffer_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (want_wr),
        .wr_data  (wr_entry),
        .wr_ok    (wr_ok),
        .rd_valid (m_valid),
        .rd_ready (m_ready),
        .rd_data  (rd_entry)
    );

    // Totals including this cycle's accepted match, so a match coinciding with
    // match_done lands in the frame being reported.
    always_comb begin
        cnt_inc    = cnt_q;
        sum_dx_inc = sum_dx_q;
        sum_dy_inc = sum_dy_q;
        if (accepted) begin
            cnt_inc    = cnt_q + 1'b1;
            sum_dx_inc = sum_dx_q + dx_ext;
            sum_dy_inc = sum_dy_q + dy_ext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q        <= '0;
            last_valid_q  <= 1'b0;
            cnt_q         <= '0;
            sum_dx_q      <= '0;
            sum_dy_q      <= '0;
            overflow_q    <= 1'b0;
            stat_valid_q  <= 1'b0;
            stat_cnt_q    <= '0;
            stat_sum_dx_q <= '0;
            stat_sum_dy_q <= '0;
        end else begin
            if (accepted) begin
                last_q <= match_addr;
            end
            if (match_done) begin
                last_valid_q  <= 1'b0;
                cnt_q         <= '0;
                sum_dx_q      <= '0;
                sum_dy_q      <= '0;
                stat_cnt_q    <= cnt_inc;
                stat_sum_dx_q <= sum_dx_inc;
                stat_sum_dy_q <= sum_dy_inc;
            end else begin
                if (accepted) begin
                    last_valid_q <= 1'b1;
                end
                cnt_q    <= cnt_inc;
                sum_dx_q <= sum_dx_inc;
                sum_dy_q <= sum_dy_inc;
            end
            stat_valid_q <= match_done;
            // Clears the cycle after a stat strobe unless a new drop happens then.
            overflow_q   <= drop_full || (overflow_q && !stat_valid_q);
        end
    end

    assign m_seed1     = rd_entry.seed1;
    assign m_dx        = rd_entry.dx;
    assign m_dy        = rd_entry.dy;
    assign overflow    = overflow_q;
    assign stat_valid  = stat_valid_q;
    assign stat_cnt    = stat_cnt_q;
    assign stat_sum_dx = stat_sum_dx_q;
    assign stat_sum_dy = stat_sum_dy_q;

endmodule

// File: tb/tb_match_pair_buffer.sv
// Self-checking bench for match_pair_buffer: a table of single-match vectors plus
// directed sequences for duplicates, overflow, full-FIFO write/read and mid-frame reset.
module tb_match_pair_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_match;
    logic [31:0] match_addr;
    logic        match_done;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_seed1;
    logic [8:0]  m_dx;
    logic [8:0]  m_dy;
    logic        overflow;
    logic        stat_valid;
    logic [6:0]  stat_cnt;
    logic [15:0] stat_sum_dx;
    logic [15:0] stat_sum_dy;

    int checks   = 0;
    int failures = 0;
    int xfer_cnt = 0;

    typedef struct {
        logic [15:0] s1;
        logic [15:0] s2;
        logic [8:0]  dx;
        logic [8:0]  dy;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m_valid && m_ready) xfer_cnt <= xfer_cnt + 1;
    end

    match_pair_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .valid_match (valid_match),
        .match_addr  (match_addr),
        .match_done  (match_done),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_seed1     (m_seed1),
        .m_dx        (m_dx),
        .m_dy        (m_dy),
        .overflow    (overflow),
        .stat_valid  (stat_valid),
        .stat_cnt    (stat_cnt),
        .stat_sum_dx (stat_sum_dx),
        .stat_sum_dy (stat_sum_dy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] addr);
        valid_match = 1'b1;
        match_addr  = addr;
        tick();
        valid_match = 1'b0;
    endtask

    task automatic done_pulse();
        match_done = 1'b1;
        tick();
        match_done = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " m_valid"}, 32'(m_valid), 32'd0);
        check({tag, " m_seed1"}, 32'(m_seed1), 32'd0);
        check({tag, " overflow"}, 32'(overflow), 32'd0);
        check({tag, " stat_valid"}, 32'(stat_valid), 32'd0);
        check({tag, " stat_cnt"}, 32'(stat_cnt), 32'd0);
        check({tag, " stat_sum_dx"}, 32'(stat_sum_dx), 32'd0);
        check({tag, " stat_sum_dy"}, 32'(stat_sum_dy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n0;
        logic [15:0] exp_s1;

        vecs[0] = '{16'h0810, 16'h0A14, 9'h004, 9'h002};
        vecs[1] = '{16'h05C8, 16'h0532, 9'h16A, 9'h000};
        vecs[2] = '{16'h00FF, 16'hFF00, 9'h101, 9'h0FF};
        vecs[3] = '{16'hFF00, 16'h00FF, 9'h0FF, 9'h101};
        vecs[4] = '{16'h1234, 16'h1234, 9'h000, 9'h000};
        vecs[5] = '{16'h8080, 16'h7F81, 9'h001, 9'h1FF};

        rst         = 1'b1;
        valid_match = 1'b0;
        match_addr  = '0;
        match_done  = 1'b0;
        m_ready     = 1'b0;
        #3;
        check_idle_outputs("reset");
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_idle_outputs("post_reset");

        // Table of single matches, each drained immediately.
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send({vecs[i].s2, vecs[i].s1});
            check($sformatf("vec%0d m_valid", i), 32'(m_valid), 32'd1);
            check($sformatf("vec%0d m_seed1", i), 32'(m_seed1), 32'(vecs[i].s1));
            check($sformatf("vec%0d m_dx", i), 32'(m_dx), 32'(vecs[i].dx));
            check($sformatf("vec%0d m_dy", i), 32'(m_dy), 32'(vecs[i].dy));
            tick();
            check($sformatf("vec%0d drained", i), 32'(m_valid), 32'd0);
        end
        done_pulse();
        check("table stat_valid", 32'(stat_valid), 32'd1);
        check("table stat_cnt", 32'(stat_cnt), 32'd6);
        check("table sum_dx", 32'(stat_sum_dx), 32'h0000FF6F);
        check("table sum_dy", 32'(stat_sum_dy), 32'h00000001);
        tick();
        check("table stat_valid drop", 32'(stat_valid), 32'd0);
        check("table stat_cnt hold", 32'(stat_cnt), 32'd6);

        // Three identical back-to-back matches: only the first is kept.
        n0 = xfer_cnt;
        valid_match = 1'b1;
        match_addr  = 32'h0532_05C8;
        tick();
        tick();
        tick();
        valid_match = 1'b0;
        tick();
        tick();
        done_pulse();
        check("dup words", 32'(xfer_cnt - n0), 32'd1);
        check("dup stat_cnt", 32'(stat_cnt), 32'd1);
        check("dup sum_dx", 32'(stat_sum_dx), 32'h0000FF6A);
        check("dup sum_dy", 32'(stat_sum_dy), 32'd0);
        check("dup overflow", 32'(overflow), 32'd0);
        tick();

        // 70 distinct matches into a stalled output: 64 kept, overflow set.
        m_ready = 1'b0;
        for (int i = 0; i < 70; i++) begin
            send({8'h01, 8'(i + 3), 8'h00, 8'(i)});
        end
        check("ovf overflow", 32'(overflow), 32'd1);
        check("ovf m_valid", 32'(m_valid), 32'd1);
        check("ovf head", 32'(m_seed1), 32'h0000);
        done_pulse();
        check("ovf stat_valid", 32'(stat_valid), 32'd1);
        check("ovf stat_cnt", 32'(stat_cnt), 32'd64);
        check("ovf sum_dx", 32'(stat_sum_dx), 32'h00C0);
        check("ovf sum_dy", 32'(stat_sum_dy), 32'h0040);
        check("ovf overflow at stat", 32'(overflow), 32'd1);
        tick();
        check("ovf overflow cleared", 32'(overflow), 32'd0);
        m_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            check($sformatf("drain%0d m_valid", i), 32'(m_valid), 32'd1);
            check($sformatf("drain%0d m_seed1", i), 32'(m_seed1), 32'(i));
            tick();
        end
        check("drain empty", 32'(m_valid), 32'd0);
        m_ready = 1'b0;
        tick();

        // Full FIFO, write and read in the same cycle.
        for (int i = 0; i < 64; i++) begin
            send({8'h41, 8'(i), 8'h40, 8'(i)});
        end
        check("full overflow pre", 32'(overflow), 32'd0);
        valid_match = 1'b1;
        match_addr  = 32'hBEEF_BEEF;
        m_ready     = 1'b1;
        tick();
        valid_match = 1'b0;
        m_ready     = 1'b0;
        check("full overflow post", 32'(overflow), 32'd0);
        check("full m_valid", 32'(m_valid), 32'd1);
        check("full new head", 32'(m_seed1), 32'h4001);
        done_pulse();
        check("full stat_cnt", 32'(stat_cnt), 32'd65);
        check("full sum_dy", 32'(stat_sum_dy), 32'h0040);
        tick();
        m_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            exp_s1 = (i < 63) ? {8'h40, 8'(i + 1)} : 16'hBEEF;
            check($sformatf("fdrain%0d m_valid", i), 32'(m_valid), 32'd1);
            check($sformatf("fdrain%0d m_seed1", i), 32'(m_seed1), 32'(exp_s1));
            tick();
        end
        check("fdrain empty", 32'(m_valid), 32'd0);
        m_ready = 1'b0;
        tick();

        // Reset while 10 words are buffered and a frame is in progress.
        for (int i = 0; i < 10; i++) begin
            send({8'h22, 8'(i + 1), 8'h20, 8'(i)});
        end
        check("rst pre m_valid", 32'(m_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst async m_valid", 32'(m_valid), 32'd0);
        check("rst async m_seed1", 32'(m_seed1), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_idle_outputs("rst release");
        m_ready = 1'b0;
        send(32'h0A14_0810);
        check("rst new head valid", 32'(m_valid), 32'd1);
        check("rst new head seed1", 32'(m_seed1), 32'h0810);
        done_pulse();
        check("rst stat_cnt", 32'(stat_cnt), 32'd1);
        check("rst sum_dx", 32'(stat_sum_dx), 32'h0004);
        check("rst sum_dy", 32'(stat_sum_dy), 32'h0002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
